scoreboard_stall_unit: RTL
==========================

Name: scoreboard_stall_unit

Overview:
- Producer-side companion to the scalar pipeline's EX/WB operand forwarding network.
- Tracks, per architectural register, how many cycles remain until a multi-cycle producer (load, MUL, vector-to-scalar move) has a result the forwarding muxes can deliver.
- Raises a decode-stage stall whenever an instruction reads a register that forwarding cannot yet supply.
- Sits beside the decode/issue stage and drives the IF/ID hold and ID/EX bubble controls.

Parameters:
- NREG, 16, number of scalar registers; register 0 is hardwired zero and never pending.
- RW, 4, register index width (log2 NREG).
- LW, 3, latency counter width; maximum tracked latency is 2^LW-1.
- SCW, 16, stall-cycle performance counter width.

Ports:
- clk  in  1  pipeline clock; all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode-stage instruction is presented for issue this cycle.
- issue_dest  in  RW  destination register of the issuing instruction.
- issue_lat  in  LW  cycles until the result is forwardable; 0 means ALU-class, already covered by the forwarding network.
- src_a  in  RW  first source register index of the decoding instruction.
- src_b  in  RW  second source register index.
- src_a_used  in  1  src_a is a real register read, not an immediate slot.
- src_b_used  in  1  src_b is a real register read.
- wb_valid  in  1  early result-ready notice from memory/MUL.
- wb_dest  in  RW  register named by wb_valid.
- flush  in  1  branch redirect; kills the decoding instruction.
- stall  out  1  hold IF/ID and insert an ID/EX bubble.
- pending  out  NREG  per-register busy vector; bit i = counter i nonzero.
- stall_cycles  out  SCW  saturating count of stalled cycles (optional feature).

Behaviour:
- Reset (async, rst_n=0): all counters=0, pending=0, stall=0, stall_cycles=0. Reset mid-operation discards all outstanding entries immediately.
- State: one LW-bit down-counter per register; cnt[0] is constant 0.
- Stall rule (combinational from registered state): stall = ~flush & ((src_a_used & src_a!=0 & pending[src_a]) | (src_b_used & src_b!=0 & pending[src_b])).
- Accepted issue: accept = issue_valid & ~stall & ~flush. On accept with issue_lat!=0 and issue_dest!=0, cnt[issue_dest] <= issue_lat at the next edge.
- Every other nonzero counter decrements by 1 per cycle and saturates at 0. An entry loaded with latency L keeps its register pending for exactly L cycles after issue.
- Early completion: wb_valid with wb_dest!=0 clears cnt[wb_dest] to 0 at the next edge.
- Simultaneous events on the same register:
  - Accepted issue overrides both wb clear and decrement; the newer producer wins.
  - wb clear overrides decrement.
- Rejected issue: a stalled or flushed issue leaves no entry. Entries from older instructions continue counting through a flush.
- Issue with issue_lat=0, or to register 0: no state change.
- issue_lat values are never truncated or wrapped; the full LW range 1..2^LW-1 is honoured.
- Stall latency: a register becomes visible as pending in the cycle after issue. Back-to-back dependent instructions therefore stall starting on cycle 1 after the producer issues.

Optional Feature:
- Macro: SCOREBOARD_STALL_CNT_EN.
- Defined: stall_cycles increments on every cycle with stall=1 and saturates at 2^SCW-1; it is never cleared except by reset.
- Undefined: no counter flops; stall_cycles is tied to 0.

Test Plan:
- Load-use: issue dest=5 lat=2; next cycle src_a=5 used -> stall=1 for 2 cycles, pending[5] 1→1→0, stall drops on cycle 3.
- Register 0 / unused sources: issue dest=0 lat=3 -> pending=0. src_b=7 with src_b_used=0 while pending[7]=1 -> stall=0.
- Early wb: issue dest=3 lat=7; wb_valid wb_dest=3 two cycles later -> pending[3]=0 next edge, stall released early.
- Collision: cnt[9]=1 while wb_dest=9 and an accepted issue dest=9 lat=4 arrive together -> cnt[9]=4, pending[9] stays 1 for 4 more cycles.
- Flush: flush=1 with issue dest=2 lat=3 and pending src -> stall=0, no entry for r2. An older entry on r4 keeps decrementing.
- Async reset during 3 pending entries -> pending=0 and stall=0 immediately without a clock. With SCOREBOARD_STALL_CNT_EN, stall_cycles counts 2 after the load-use case and resets to 0.

Source files
------------

// File: rtl/scoreboard_stall_unit.sv
// Decode-stage stall scoreboard for multi-cycle producers.
// Each register has a down-counter that holds the number of cycles left
// before its result can be forwarded. An instruction that reads a register
// whose counter is still nonzero is held in decode.
// Optional build macro: SCOREBOARD_STALL_CNT_EN adds a saturating
// stalled-cycle performance counter on stall_cycles.
module scoreboard_stall_unit #(
   parameter int unsigned NREG = 16,
   parameter int unsigned RW   = 4,
   parameter int unsigned LW   = 3,
   parameter int unsigned SCW  = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            issue_valid,
   input  logic [RW-1:0]   issue_dest,
   input  logic [LW-1:0]   issue_lat,
   input  logic [RW-1:0]   src_a,
   input  logic [RW-1:0]   src_b,
   input  logic            src_a_used,
   input  logic            src_b_used,
   input  logic            wb_valid,
   input  logic [RW-1:0]   wb_dest,
   input  logic            flush,
   output logic            stall,
   output logic [NREG-1:0] pending,
   output logic [SCW-1:0]  stall_cycles
);

   logic [LW-1:0] cnt_q [NREG];
   logic [LW-1:0] cnt_d [NREG];
   logic          hit_a;
   logic          hit_b;
   logic          accept;

   // Busy vector straight from the registered counters.
   always_comb begin
      pending = '0;
      for (int i = 0; i < NREG; i++) begin
         pending[i] = (cnt_q[i] != '0);
      end
   end

   assign hit_a  = src_a_used & (src_a != '0) & pending[src_a];
   assign hit_b  = src_b_used & (src_b != '0) & pending[src_b];
   assign stall  = ~flush & (hit_a | hit_b);
   assign accept = issue_valid & ~stall & ~flush;

   // Next counter value: new producer beats early clear, which beats decrement.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         cnt_d[i] = cnt_q[i];
         if (i == 0) begin
            cnt_d[i] = '0;
         end else if (accept && (issue_lat != '0) && (issue_dest == RW'(i))) begin
            cnt_d[i] = issue_lat;
         end else if (wb_valid && (wb_dest == RW'(i))) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - LW'(1);
         end
      end
   end

   // Counter state; reset discards every outstanding entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

`ifdef SCOREBOARD_STALL_CNT_EN
   logic [SCW-1:0] sc_q;

   // Saturating count of stalled cycles, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sc_q <= '0;
      end else if (stall && (sc_q != '1)) begin
         sc_q <= sc_q + SCW'(1);
      end
   end

   assign stall_cycles = sc_q;
`else
   assign stall_cycles = '0;
`endif

endmodule
